// File: rtl/mult_16b_seq.sv
// ----------------------------------------------------------------------------
// mult_16b_seq : unsigned 16x16 shift-and-add multiplier around an external CLA
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mult_16b_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_s,
  input  logic                 add_cout
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = in_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Encoding 2'b11 is unreachable; it falls through to IDLE.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Each RUN step adds the gated multiplicand into hi and shifts {cout,hi,lo} right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand <= in_a;
            lo    <= in_b;
            hi    <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          hi  <= {add_cout, add_s[WIDTH-1:1]};
          lo  <= {add_s[0], lo[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_prod  = {hi, lo};

  // Adder inputs are forced to zero outside RUN so the adder stays quiet.
  assign add_a   = (state == RUN) ? hi : '0;
  assign add_b   = ((state == RUN) && lo[0]) ? mcand : '0;
  assign add_cin = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_mult_16b_seq.sv
// ----------------------------------------------------------------------------
// tb_mult_16b_seq : directed + random scoreboard bench for mult_16b_seq
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mult_16b_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_prod;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_s;
  logic        add_cout;

  int          passed;
  int          failed;
  int          total;
  logic [31:0] sb[$];

  mult_16b_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout)
  );

  // Behavioural stand-in for the 16-bit carry-lookahead adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then wait until out_valid; lat = edges from accept to out_valid.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int busy_rdy, output int nz_addb);
    int w;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    w        = 0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    if (in_ready) sb.push_back(32'(a) * 32'(b));
    tick();
    in_valid = 1'b0;
    lat      = 0;
    busy_rdy = 0;
    nz_addb  = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_rdy++;
      if (add_b != 16'd0) nz_addb++;
      tick();
      lat++;
    end
  endtask

  task automatic take_result(input string tag);
    logic [31:0] exp;
    out_ready = 1'b1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_rdy_done"}, {31'd0, in_ready}, 32'd0);
    exp = 32'hDEAD_BEEF;
    if (sb.size() > 0) exp = sb.pop_front();
    check({tag, "_prod"}, out_prod, exp);
    tick();
    out_ready = 1'b0;
    check({tag, "_back_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int busy;
    int nzb;
    int sent;
    int recv;
    int cyc;
    logic pend;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] exp;

    passed    = 0;
    failed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 16'd0;
    in_b      = 16'd0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_prod", out_prod, 32'd0);
    check("rst_add_a", {16'd0, add_a}, 32'd0);
    check("rst_add_b", {16'd0, add_b}, 32'd0);
    check("rst_add_cin", {31'd0, add_cin}, 32'd0);

    // 3 * 5 with out_ready held high
    out_ready = 1'b1;
    start_op(16'h0003, 16'h0005, lat, busy, nzb);
    check("t1_latency", 32'(lat), 32'd16);
    check("t1_busy_rdy", 32'(busy), 32'd0);
    check("t1_prod_const", out_prod, 32'h0000_000F);
    take_result("t1");

    // Carry-out capture on every step
    start_op(16'hFFFF, 16'hFFFF, lat, busy, nzb);
    check("t2_latency", 32'(lat), 32'd16);
    check("t2_prod_const", out_prod, 32'hFFFE_0001);
    take_result("t2");

    // Zero operands; multiplier zero keeps add_b quiet
    start_op(16'h1234, 16'h0000, lat, busy, nzb);
    check("t3a_addb_nonzero", 32'(nzb), 32'd0);
    take_result("t3a");
    start_op(16'h0000, 16'hABCD, lat, busy, nzb);
    take_result("t3b");

    // Backpressure: result held, new requests ignored
    start_op(16'h00FF, 16'h0100, lat, busy, nzb);
    for (int i = 0; i < 5; i++) begin
      in_a     = 16'h0002;
      in_b     = 16'h0003;
      in_valid = 1'b1;
      check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t4_hold_prod", out_prod, 32'h0000_FF00);
      check("t4_hold_rdy", {31'd0, in_ready}, 32'd0);
      tick();
    end
    take_result("t4");
    check("t4_valid_low", {31'd0, out_valid}, 32'd0);
    start_op(16'h0002, 16'h0003, lat, busy, nzb);
    check("t4n_latency", 32'(lat), 32'd16);
    take_result("t4n");

    // Asynchronous reset mid-RUN
    in_a     = 16'h8001;
    in_b     = 16'h7FFF;
    in_valid = 1'b1;
    check("t5_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_rdy", {31'd0, in_ready}, 32'd1);
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_prod", out_prod, 32'd0);
    check("t5_rst_add_a", {16'd0, add_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t5_idle_after", {31'd0, in_ready}, 32'd1);
    start_op(16'h8001, 16'h7FFF, lat, busy, nzb);
    check("t5_prod_const", out_prod, 32'h3FFF_FFFF);
    take_result("t5");

    // Random back-to-back stream with random out_ready
    sent = 0;
    recv = 0;
    cyc  = 0;
    pend = 1'b0;
    ra   = 16'd0;
    rb   = 16'd0;
    while (recv < 1000 && cyc < 60000) begin
      if (!pend && sent < 1000) begin
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        pend = 1'b1;
      end
      in_a      = ra;
      in_b      = rb;
      in_valid  = pend;
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        sb.push_back(32'(ra) * 32'(rb));
        pend = 1'b0;
        sent++;
      end
      if (out_valid && out_ready) begin
        exp = 32'hDEAD_BEEF;
        if (sb.size() > 0) exp = sb.pop_front();
        check("rnd_prod", out_prod, exp);
        recv++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rnd_recv_count", 32'(recv), 32'd1000);
    check("rnd_sb_empty", 32'(sb.size()), 32'd0);
    repeat (20) tick();
    check("rnd_no_extra", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
